gcd_feeder: RTL
===============

GCD_FEEDER -- requirements
Module: gcd_feeder

Interface
REQ-001 Parameter TIMEOUT_CYC, default 4096: maximum cycles spent in WAIT before the transaction is aborted.
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 RST  input  1  synchronous, active-high reset.
REQ-004 IN_VALID  input  1  operand pair on IN_A/IN_B is valid.
REQ-005 IN_READY  output  1  block can accept an operand pair.
REQ-006 IN_A, IN_B  input  16 each  unsigned operands.
REQ-007 GCD_START  output  1  to GCD START; marks the high-byte beat.
REQ-008 GCD_A, GCD_B  output  8 each  to GCD A/B; byte-serial operands.
REQ-009 GCD_Y  input  8  from GCD Y; byte-serial result.
REQ-010 GCD_DONE, GCD_ERROR  input  1 each  from GCD DONE/ERROR.
REQ-011 OUT_VALID  output  1  result on OUT_Y/OUT_ERR/OUT_TMO is valid.
REQ-012 OUT_READY  input  1  downstream accepts the result.
REQ-013 OUT_Y  output  16  assembled GCD result.
REQ-014 OUT_ERR  output  1  GCD reported ERROR for this pair.
REQ-015 OUT_TMO  output  1  transaction aborted by timeout.

Function
REQ-016 FSM states SHALL be IDLE, SEND_HI, SEND_LO, WAIT, RECV_LO, HOLD.
REQ-017 IN_READY SHALL be 1 only in IDLE; a transfer occurs on IN_VALID&&IN_READY at a rising edge.
REQ-018 On transfer, IN_A/IN_B SHALL be registered and the FSM SHALL move IDLE->SEND_HI.
REQ-019 SEND_HI: GCD_START=1, GCD_A=A[15:8], GCD_B=B[15:8]; always -> SEND_LO next cycle.
REQ-020 SEND_LO: GCD_START=0, GCD_A=A[7:0], GCD_B=B[7:0]; always -> WAIT; timeout counter cleared.
REQ-021 In WAIT, RECV_LO, HOLD and IDLE, GCD_START SHALL be 0 and GCD_A/GCD_B SHALL hold the low bytes last driven (0 after reset).
REQ-022 WAIT: on GCD_DONE=1, capture GCD_Y into OUT_Y[15:8] and GCD_ERROR into the error flag, then -> RECV_LO.
REQ-023 RECV_LO: capture GCD_Y into OUT_Y[7:0] unconditionally, then -> HOLD.
REQ-024 WAIT timeout: the counter increments each WAIT cycle without DONE; on reaching TIMEOUT_CYC-1 with no DONE -> HOLD with OUT_Y=0, OUT_ERR=0, OUT_TMO=1.
REQ-025 DONE on the same cycle the counter hits its limit SHALL take precedence (normal capture, OUT_TMO=0).
REQ-026 HOLD: OUT_VALID=1; OUT_Y/OUT_ERR/OUT_TMO stable; -> IDLE on OUT_READY=1.
REQ-027 OUT_VALID SHALL be 0 in every state other than HOLD.
REQ-028 GCD_DONE outside WAIT SHALL be ignored.
REQ-029 Latency: transfer at edge t -> GCD_START high in cycle t+1; OUT_VALID first high 2 cycles after the edge sampling GCD_DONE.
REQ-030 Back-to-back throughput: IN_READY SHALL reassert in the cycle after the OUT_READY handshake edge; no operands are buffered beyond one pair.
REQ-031 Operand values, including zero, SHALL be forwarded unmodified; error detection belongs to the GCD.

Reset
REQ-032 With RST=1 at an edge: FSM=IDLE, IN_READY=1 after reset release, GCD_START=0, GCD_A=GCD_B=0, OUT_VALID=0, OUT_Y=0, OUT_ERR=0, OUT_TMO=0, counter=0.
REQ-033 RST SHALL override every state, including mid-transaction (SEND_*, WAIT, HOLD); the in-flight pair is discarded with no output produced.

Verification
REQ-034 Pair (900,450) -> GCD bytes (3,1) with START=1, then (132,194); GCD returns Y=1 then 194 after DONE -> OUT_Y=450, OUT_ERR=0, OUT_TMO=0.
REQ-035 Pair (3096,1428) -> bytes (12,5), (24,148); result OUT_Y=12; OUT_READY held 0 for 5 cycles -> OUT_VALID and OUT_Y stay stable, IN_READY=0 throughout.
REQ-036 Pair (0,0) with GCD_ERROR=1 at DONE -> OUT_ERR=1, OUT_TMO=0; then pair (0,259) -> bytes (0,1), (0,3) -> OUT_Y=259.
REQ-037 GCD model never asserts DONE, TIMEOUT_CYC=16 -> OUT_VALID after exactly 16 WAIT cycles with OUT_TMO=1, OUT_Y=0; a spurious DONE while in HOLD has no effect.
REQ-038 RST=1 asserted during WAIT -> next cycle all outputs at reset values; a following pair (450,900) completes normally with OUT_Y=450.

Source files
------------

// File: rtl/gcd_feeder_if.sv
// Handshake and byte-serial GCD bus between the gcd_feeder and its environment.
// master = feeder side, slave = upstream producer / GCD core / downstream consumer.
interface gcd_feeder_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        gcd_start;
  logic [7:0]  gcd_a;
  logic [7:0]  gcd_b;
  logic [7:0]  gcd_y;
  logic        gcd_done;
  logic        gcd_error;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_y;
  logic        out_err;
  logic        out_tmo;

  modport master (
    input  in_valid, in_a, in_b, gcd_y, gcd_done, gcd_error, out_ready,
    output in_ready, gcd_start, gcd_a, gcd_b, out_valid, out_y, out_err, out_tmo
  );

  modport slave (
    output in_valid, in_a, in_b, gcd_y, gcd_done, gcd_error, out_ready,
    input  in_ready, gcd_start, gcd_a, gcd_b, out_valid, out_y, out_err, out_tmo
  );
endinterface

// File: rtl/gcd_feeder.sv
// Splits a 16-bit operand pair into two byte beats for an 8-bit GCD core, reassembles
// the byte-serial result, and aborts with a timeout flag if the core never answers.
module gcd_feeder #(
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic          i_clk,
  input  logic          i_rst,
  gcd_feeder_if.master  io_bus
);

  localparam int unsigned   CNT_W    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND_HI,
    S_SEND_LO,
    S_WAIT,
    S_RECV_LO,
    S_HOLD
  } state_t;

  state_t           r_state;
  logic [7:0]       r_a_lo;
  logic [7:0]       r_b_lo;
  logic [CNT_W-1:0] r_cnt;
  logic             r_in_ready;
  logic             r_gcd_start;
  logic [7:0]       r_gcd_a;
  logic [7:0]       r_gcd_b;
  logic             r_out_valid;
  logic [15:0]      r_out_y;
  logic             r_out_err;
  logic             r_out_tmo;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_a_lo      <= 8'h00;
      r_b_lo      <= 8'h00;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_gcd_start <= 1'b0;
      r_gcd_a     <= 8'h00;
      r_gcd_b     <= 8'h00;
      r_out_valid <= 1'b0;
      r_out_y     <= 16'h0000;
      r_out_err   <= 1'b0;
      r_out_tmo   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // High bytes go straight out; only the low bytes need to be kept.
          if (io_bus.in_valid) begin
            r_a_lo      <= io_bus.in_a[7:0];
            r_b_lo      <= io_bus.in_b[7:0];
            r_gcd_a     <= io_bus.in_a[15:8];
            r_gcd_b     <= io_bus.in_b[15:8];
            r_gcd_start <= 1'b1;
            r_in_ready  <= 1'b0;
            r_state     <= S_SEND_HI;
          end
        end
        S_SEND_HI: begin
          r_gcd_start <= 1'b0;
          r_gcd_a     <= r_a_lo;
          r_gcd_b     <= r_b_lo;
          r_state     <= S_SEND_LO;
        end
        S_SEND_LO: begin
          r_cnt   <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          // DONE wins over a timeout landing on the same cycle.
          if (io_bus.gcd_done) begin
            r_out_y[15:8] <= io_bus.gcd_y;
            r_out_err     <= io_bus.gcd_error;
            r_out_tmo     <= 1'b0;
            r_state       <= S_RECV_LO;
          end else if (r_cnt == CNT_LAST) begin
            r_out_y     <= 16'h0000;
            r_out_err   <= 1'b0;
            r_out_tmo   <= 1'b1;
            r_out_valid <= 1'b1;
            r_state     <= S_HOLD;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_RECV_LO: begin
          r_out_y[7:0] <= io_bus.gcd_y;
          r_out_valid  <= 1'b1;
          r_state      <= S_HOLD;
        end
        S_HOLD: begin
          if (io_bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_gcd_start <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign io_bus.in_ready  = r_in_ready;
  assign io_bus.gcd_start = r_gcd_start;
  assign io_bus.gcd_a     = r_gcd_a;
  assign io_bus.gcd_b     = r_gcd_b;
  assign io_bus.out_valid = r_out_valid;
  assign io_bus.out_y     = r_out_y;
  assign io_bus.out_err   = r_out_err;
  assign io_bus.out_tmo   = r_out_tmo;

endmodule
